// File: rtl/bnn_dot_acc.sv
// Binary (+1/-1) dot-product accumulator: sums LANES-wide XNOR beats over a
// vector starting from a signed bias, saturates to ACC_W bits and returns one
// result per vector over a valid/ready handshake.
module bnn_dot_acc #(
    parameter int unsigned LANES = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_x,
    input  logic [LANES-1:0] in_w,
    input  logic [ACC_W-1:0] in_bias,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat
);

    // Two guard bits keep bias + beat_sum exact before clamping.
    localparam int unsigned SW = ACC_W + 2;
    localparam logic signed [SW-1:0] MaxVal = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MinVal = {3'b111, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ACC_W-1:0]       r_acc;
    logic                   r_sat;
    logic [ACC_W-1:0]       r_out_acc;
    logic                   r_out_sat;

    logic [LANES-1:0]       w_match;
    logic [SW-1:0]          w_pop;
    logic signed [SW-1:0]   w_beat;
    logic                   w_new_vec;
    logic [ACC_W-1:0]       w_base;
    logic signed [SW-1:0]   w_sum;
    logic [ACC_W-1:0]       w_res;
    logic                   w_clamp;
    logic                   w_sat_next;
    logic                   w_accept;

    assign w_match = ~(in_x ^ in_w);

    // Count agreeing lanes.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_pop = w_pop + {{(SW-1){1'b0}}, w_match[i]};
        end
    end

    assign w_beat    = $signed((w_pop << 1) - SW'(LANES));
    // IDLE and HOLD both start a fresh vector from the bias.
    assign w_new_vec = (r_state != StAcc);
    assign w_base    = w_new_vec ? in_bias : r_acc;
    assign w_sum     = $signed({{2{w_base[ACC_W-1]}}, w_base}) + w_beat;

    // Clamp the wide sum into the signed ACC_W range.
    always_comb begin
        w_res   = w_sum[ACC_W-1:0];
        w_clamp = 1'b0;
        if (w_sum > MaxVal) begin
            w_res   = MaxVal[ACC_W-1:0];
            w_clamp = 1'b1;
        end else if (w_sum < MinVal) begin
            w_res   = MinVal[ACC_W-1:0];
            w_clamp = 1'b1;
        end
    end

    assign w_sat_next = w_clamp | (~w_new_vec & r_sat);
    assign in_ready   = (r_state == StHold) ? out_ready : 1'b1;
    assign out_valid  = (r_state == StHold);
    assign w_accept   = in_valid & in_ready;
    assign out_acc    = r_out_acc;
    assign out_sat    = r_out_sat;

    // Next-state selection for the vector sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = in_last ? StHold : StAcc;
            end
            StAcc: begin
                if (w_accept && in_last) w_state_next = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    if (w_accept) w_state_next = in_last ? StHold : StAcc;
                    else          w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= StIdle;
        else      r_state <= w_state_next;
    end

    // Accumulator and result registers; only accepted beats touch them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_out_acc <= '0;
            r_out_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_res;
            r_sat <= w_sat_next;
            if (in_last) begin
                r_out_acc <= w_res;
                r_out_sat <= w_sat_next;
            end
        end
    end

endmodule
